mem_stage_unit: RTL

//  Consumer (read side) of the EX/MEM pipeline register: takes the registered EX/MEM fields and runs the MEM stage.

---
 rtl/mem_stage_pkg.sv | 10 +
 rtl/mem_timeout_cnt.sv | 42 ++++
 rtl/mem_stage_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage.
//  mem_state_t : access FSM states (IDLE, WAIT, DONE)
//  INSTR_NOP   : ex_InstrType encoding of a pipeline bubble
package mem_stage_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  localparam logic [2:0] INSTR_NOP = 3'd0;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts the cycles the access FSM spends waiting for mem_ack.
//  clk       in  rising-edge clock
//  rst_n     in  asynchronous, active-low reset
//  clr_i     in  force count to 0 (has priority over en_i)
//  en_i      in  increment count
//  expired_o out high during the TIMEOUT-th enabled cycle since clear
module mem_timeout_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count starts at 0 on the first waiting cycle, so the TIMEOUT-th
  // waiting cycle is the one where the count equals TIMEOUT-1.
  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: reads the EX/MEM register, performs one handshaked
// data-memory access per load/store (with timeout) and presents registered
// writeback fields for MEM/WB.
//  clk, reset       clock, asynchronous active-low reset
//  ex_*             EX/MEM register fields
//  mem_req/we/addr/wdata  memory request side, held until mem_ack
//  mem_ack/rdata    memory completion pulse and read data
//  stall            holds EX/MEM while an access is in flight (combinational)
//  wb_valid/data/rd writeback fields for MEM/WB
//  mem_err          one-cycle pulse when an access is aborted by timeout
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic [DATA_W-1:0] ex_A,
  input  logic [DATA_W-1:0] ex_B,
  input  logic [DATA_W-1:0] ex_ALUresult,
  input  logic              ex_MemtoReg,
  input  logic              ex_MemWrite,
  input  logic              ex_MemAddrSrc,
  input  logic [2:0]        ex_InstrType,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              mem_err
);

  mem_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wbv_q, wbv_d;
  logic [DATA_W-1:0] wbd_q, wbd_d;
  logic [REG_W-1:0]  wbrd_q, wbrd_d;
  logic              err_q, err_d;
  logic [REG_W-1:0]  rd_lat_q, rd_lat_d;
  logic              ld_lat_q, ld_lat_d;

  logic              valid_instr, access;
  logic [DATA_W-1:0] addr_sel;
  logic              cnt_clr, cnt_en, expired;

  // rt is carried in the EX/MEM register but plays no part in this stage.
  logic unused_rt;
  assign unused_rt = ^ex_rt;

  assign valid_instr = (ex_InstrType != INSTR_NOP);
  assign access      = (ex_MemtoReg | ex_MemWrite) & valid_instr;
  assign addr_sel    = ex_MemAddrSrc ? ex_A : ex_ALUresult;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wbv_d    = wbv_q;
    wbd_d    = wbd_q;
    wbrd_d   = wbrd_q;
    err_d    = err_q;
    rd_lat_d = rd_lat_q;
    ld_lat_d = ld_lat_q;
    stall    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        err_d   = 1'b0;
        if (access) begin
          stall    = 1'b1;
          addr_d   = addr_sel;
          wdata_d  = ex_B;
          we_d     = ex_MemWrite;
          rd_lat_d = ex_rd;
          ld_lat_d = ex_MemtoReg;
          req_d    = 1'b1;
          wbv_d    = 1'b0;
          state_d  = WAIT;
        end else begin
          wbv_d  = valid_instr;
          wbd_d  = ex_ALUresult;
          wbrd_d = ex_rd;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        // Ack takes priority over a simultaneous timeout.
        if (mem_ack) begin
          req_d   = 1'b0;
          wbv_d   = ld_lat_q;
          if (ld_lat_q) begin
            wbd_d  = mem_rdata;
            wbrd_d = rd_lat_q;
          end
          state_d = DONE;
        end else if (expired) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          wbv_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        wbv_d   = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wbv_q    <= 1'b0;
      wbd_q    <= '0;
      wbrd_q   <= '0;
      err_q    <= 1'b0;
      rd_lat_q <= '0;
      ld_lat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wbv_q    <= wbv_d;
      wbd_q    <= wbd_d;
      wbrd_q   <= wbrd_d;
      err_q    <= err_d;
      rd_lat_q <= rd_lat_d;
      ld_lat_q <= ld_lat_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wbv_q;
  assign wb_data   = wbd_q;
  assign wb_rd     = wbrd_q;
  assign mem_err   = err_q;

endmodule
